alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one combinational ALU. A round-robin arbiter picks
// one request while idle and decodes that requester's op class and function
// field into an ALU select. It latches the select and operands, drives them to
// the ALU for one cycle, and captures the ALU result and zero flag. It then
// pulses done back to the requester that won.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req0/req1             operation requests (held until the matching gnt)
//   aluop0/1, funct0/1    op class and R-type function field per requester
//   a0/b0, a1/b1          operands per requester
//   gnt0/gnt1             one-cycle pulse: request accepted, operands latched
//   done0/done1           one-cycle pulse: result valid for that requester
//   result, zero          registered ALU outputs of the last completed op
//   illegal               pulses with done when the op failed to decode
//   busy                  high whenever the arbiter is not idle
//   alu_sel, alu_a/alu_b  drive to the shared ALU
//   alu_res, alu_zero     combinational outputs from the shared ALU
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [2:0]   aluop0,
  input  logic [2:0]   aluop1,
  input  logic [5:0]   funct0,
  input  logic [5:0]   funct1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         illegal,
  output logic         busy,
  output logic [3:0]   alu_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_res,
  input  logic         alu_zero
);

  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0001;
  localparam logic [3:0] SEL_SLT = 4'b0011;
  localparam logic [3:0] SEL_AND = 4'b0100;
  localparam logic [3:0] SEL_OR  = 4'b0101;
  localparam logic [3:0] SEL_NOP = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           rr_q, rr_d;
  logic           owner_q, owner_d;
  logic           ill_q, ill_d;
  logic [3:0]     sel_q, sel_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d;

  logic [3:0]     dec_sel0, dec_sel1;
  logic           dec_ill0, dec_ill1;
  logic           accept;
  logic           winner;

  // Maps the op class and function field onto an ALU select. The returned MSB
  // marks an illegal combination. Illegal ops still run through the ALU with
  // the neutral select, so the pipeline timing never changes.
  function automatic logic [4:0] decode_op(input logic [2:0] aluop,
                                           input logic [5:0] funct);
    logic [4:0] d;
    d = {1'b1, SEL_NOP};
    case (aluop)
      3'b000: d = {1'b0, SEL_ADD};
      3'b001: d = {1'b0, SEL_SUB};
      3'b010: begin
        case (funct)
          6'b100000: d = {1'b0, SEL_ADD};
          6'b100010: d = {1'b0, SEL_SUB};
          6'b100100: d = {1'b0, SEL_AND};
          6'b100101: d = {1'b0, SEL_OR};
          6'b101010: d = {1'b0, SEL_SLT};
          6'b000000: d = {1'b0, SEL_NOP};
          default:   d = {1'b1, SEL_NOP};
        endcase
      end
      default: d = {1'b1, SEL_NOP};
    endcase
    return d;
  endfunction

  // Both requesters are decoded in parallel. The arbiter then only has to
  // steer the result of the winner into the latches.
  always_comb begin
    {dec_ill0, dec_sel0} = decode_op(aluop0, funct0);
    {dec_ill1, dec_sel1} = decode_op(aluop1, funct1);
  end

  // Round-robin pick. When only one requester asks, it wins regardless of the
  // pointer. When both ask, the pointer decides (0 favours requester 0).
  always_comb begin
    accept = 1'b0;
    winner = 1'b0;
    if (state_q == IDLE) begin
      accept = req0 | req1;
      if (req0 && req1) begin
        winner = rr_q;
      end else begin
        winner = req1;
      end
    end
  end

  // Next-state logic. Every register holds its value by default. On acceptance
  // the winner's decoded op and operands are frozen, so later changes on that
  // requester's inputs cannot disturb the op in flight. The ALU output is
  // sampled on the EXEC->RESP edge.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    ill_d    = ill_q;
    sel_d    = sel_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          owner_d = winner;
          rr_d    = ~winner;
          if (winner) begin
            sel_d = dec_sel1;
            ill_d = dec_ill1;
            opa_d = a1;
            opb_d = b1;
          end else begin
            sel_d = dec_sel0;
            ill_d = dec_ill0;
            opa_d = a0;
            opb_d = b0;
          end
        end
      end
      EXEC: begin
        state_d  = RESP;
        result_d = alu_res;
        zero_d   = alu_zero;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything. A reset that lands in EXEC or
  // RESP drops the op: the result is not captured and done is never issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      ill_q    <= 1'b0;
      sel_q    <= SEL_NOP;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      ill_q    <= ill_d;
      sel_q    <= sel_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Outputs are decoded from the registered state only. gnt marks the EXEC
  // cycle and done marks the RESP cycle, in each case for the owner alone. The
  // ALU sees the latched op only during EXEC and is parked on a neutral select
  // with zero operands the rest of the time.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    illegal = 1'b0;
    alu_sel = SEL_NOP;
    alu_a   = '0;
    alu_b   = '0;
    if (state_q == EXEC) begin
      gnt0    = ~owner_q;
      gnt1    = owner_q;
      alu_sel = sel_q;
      alu_a   = opa_q;
      alu_b   = opb_q;
    end
    if (state_q == RESP) begin
      done0   = ~owner_q;
      done1   = owner_q;
      illegal = ill_q;
    end
  end

  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Bench for alu_share_arbiter. It provides a small combinational ALU, drives
// directed requests, and checks the outputs every cycle against a timeline
// model. The model works in terms of transactions: when a request is accepted,
// and on which cycles gnt, done and the result must appear. Directed checks
// with hand-computed values sit alongside it.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int W = 32;
  localparam logic [3:0] NOP = 4'b1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [2:0]   aluop0, aluop1;
  logic [5:0]   funct0, funct1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] result;
  logic         zero, illegal, busy;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_res;
  logic         alu_zero;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .aluop0(aluop0), .aluop1(aluop1),
    .funct0(funct0), .funct1(funct1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .illegal(illegal), .busy(busy),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Shared ALU the arbiter drives. Select 1000 is a shift-left.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0001: alu_res = alu_a - alu_b;
      4'b0100: alu_res = alu_a & alu_b;
      4'b0101: alu_res = alu_a | alu_b;
      4'b0011: alu_res = ($signed(alu_a) < $signed(alu_b)) ? {{(W-1){1'b0}}, 1'b1} : '0;
      4'b1000: alu_res = alu_a << alu_b[4:0];
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = (alu_res == '0);

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one set of requester inputs just after a rising edge.
  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [2:0] op0, input logic [5:0] f0,
                               input logic [W-1:0] x0, input logic [W-1:0] y0,
                               input logic [2:0] op1, input logic [5:0] f1,
                               input logic [W-1:0] x1, input logic [W-1:0] y1);
    @(posedge clk);
    #1;
    req0 = r0; aluop0 = op0; funct0 = f0; a0 = x0; b0 = y0;
    req1 = r1; aluop1 = op1; funct1 = f1; a1 = x1; b1 = y1;
  endtask

  // Waits a bounded number of cycles for a grant and returns its requester.
  task automatic waitGnt(output int who);
    bit seen;
    seen = 0;
    who = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        seen = 1;
        who = gnt1 ? 1 : 0;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL gnt_timeout: got no grant, required one within 12 cycles");
    end
  endtask

  // Waits a bounded number of cycles for a done and returns its requester.
  task automatic waitDone(output int who);
    bit seen;
    seen = 0;
    who = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        seen = 1;
        who = done1 ? 1 : 0;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL done_timeout: got no done, required one within 12 cycles");
    end
  endtask

  // Expected meaning of an op. Returns the select the ALU must see and
  // computes the value the requester should get back.
  function automatic void model_op(input logic [2:0] op, input logic [5:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [3:0] sel, output logic ill,
                                   output logic [W-1:0] res);
    logic [4:0] sh;
    sh  = b[4:0];
    sel = NOP;
    ill = 1'b0;
    res = a << sh;
    if (op == 3'b000) begin
      sel = 4'b0000; res = a + b;
    end else if (op == 3'b001) begin
      sel = 4'b0001; res = a - b;
    end else if (op == 3'b010) begin
      case (fn)
        6'b100000: begin sel = 4'b0000; res = a + b; end
        6'b100010: begin sel = 4'b0001; res = a - b; end
        6'b100100: begin sel = 4'b0100; res = a & b; end
        6'b100101: begin sel = 4'b0101; res = a | b; end
        6'b101010: begin sel = 4'b0011; res = ($signed(a) < $signed(b)) ? 1 : 0; end
        6'b000000: begin sel = NOP; res = a << sh; end
        default:   ill = 1'b1;
      endcase
    end else begin
      ill = 1'b1;
    end
  endfunction

  // Timeline model plus the per-cycle compare. At each rising edge it takes
  // the inputs the design also samples and decides whether a request is
  // accepted: an accept is allowed only if the previous cycle was idle. It then
  // schedules the grant and done cycles. At the following falling edge every
  // output is compared against that schedule.
  initial begin : model
    int           cyc, free_cyc, gnt_cyc, done_cyc;
    bit           ok, pend, m_rr, m_owner, m_ill, win, in_exec, in_resp;
    logic [3:0]   m_sel;
    logic [W-1:0] m_a, m_b, m_pend_res, m_result;
    logic         m_zero;
    cyc = 0; free_cyc = 0; gnt_cyc = -10; done_cyc = -10;
    ok = 0; pend = 0; m_rr = 0; m_owner = 0; m_ill = 0;
    m_sel = NOP; m_a = '0; m_b = '0; m_pend_res = '0; m_result = '0; m_zero = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        ok = 1; pend = 0; m_rr = 0; m_result = '0; m_zero = 1'b0; free_cyc = cyc;
      end else if (ok) begin
        if (pend && cyc == done_cyc) begin
          m_result = m_pend_res;
          m_zero   = (m_pend_res == '0);
        end
        if (cyc - 1 >= free_cyc && (req0 || req1)) begin
          win = (req0 && req1) ? m_rr : req1;
          if (win) begin
            model_op(aluop1, funct1, a1, b1, m_sel, m_ill, m_pend_res);
            m_a = a1; m_b = b1;
          end else begin
            model_op(aluop0, funct0, a0, b0, m_sel, m_ill, m_pend_res);
            m_a = a0; m_b = b0;
          end
          m_owner = win; m_rr = !win; pend = 1;
          gnt_cyc = cyc; done_cyc = cyc + 1; free_cyc = cyc + 2;
        end
      end
      @(negedge clk);
      if (ok) begin
        in_exec = pend && (cyc == gnt_cyc);
        in_resp = pend && (cyc == done_cyc);
        checkOutput("m_gnt0", gnt0, in_exec && !m_owner);
        checkOutput("m_gnt1", gnt1, in_exec && m_owner);
        checkOutput("m_done0", done0, in_resp && !m_owner);
        checkOutput("m_done1", done1, in_resp && m_owner);
        checkOutput("m_illegal", illegal, in_resp && m_ill);
        checkOutput("m_busy", busy, in_exec || in_resp);
        checkOutput("m_alu_sel", alu_sel, in_exec ? m_sel : NOP);
        checkOutput("m_alu_a", alu_a, in_exec ? m_a : '0);
        checkOutput("m_alu_b", alu_b, in_exec ? m_b : '0);
        checkOutput("m_result", result, m_result);
        checkOutput("m_zero", zero, m_zero);
      end
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin : stim
    int  who;
    time t_prev;
    rst = 1'b1;
    req0 = 0; req1 = 0; aluop0 = 0; aluop1 = 0; funct0 = 0; funct1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_sel", alu_sel, 4'b1000);
    checkOutput("rst_result", result, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // req0 add via function field: 5 + 7; operands disturbed during EXEC
    applyStimulus(1, 0, 3'b010, 6'b100000, 5, 7, 3'b000, 6'b0, 0, 0);
    waitGnt(who);
    checkOutput("add_gnt_who", who, 0);
    checkOutput("add_alu_sel", alu_sel, 4'b0000);
    checkOutput("add_alu_a", alu_a, 5);
    #1 req0 = 0; a0 = 100; b0 = 200;
    waitDone(who);
    checkOutput("add_done_who", who, 0);
    checkOutput("add_result", result, 12);
    checkOutput("add_zero", zero, 0);

    // req1 subtract 9 - 9 sets zero
    applyStimulus(0, 1, 3'b000, 6'b0, 0, 0, 3'b001, 6'b0, 9, 9);
    waitGnt(who);
    checkOutput("sub_gnt_who", who, 1);
    checkOutput("sub_alu_sel", alu_sel, 4'b0001);
    #1 req1 = 0;
    waitDone(who);
    checkOutput("sub_done_who", who, 1);
    checkOutput("sub_result", result, 0);
    checkOutput("sub_zero", zero, 1);

    // Illegal function field runs the neutral select: 3 << 2
    applyStimulus(1, 0, 3'b010, 6'b111111, 3, 2, 3'b000, 6'b0, 0, 0);
    waitGnt(who);
    checkOutput("ill_alu_sel", alu_sel, 4'b1000);
    #1 req0 = 0;
    waitDone(who);
    checkOutput("ill_flag", illegal, 1);
    checkOutput("ill_result", result, 12);

    // A following legal op clears the flag: 20 + 22
    applyStimulus(1, 0, 3'b000, 6'b0, 20, 22, 3'b000, 6'b0, 0, 0);
    waitGnt(who);
    #1 req0 = 0;
    waitDone(who);
    checkOutput("legal_flag", illegal, 0);
    checkOutput("legal_result", result, 42);

    // Signed set-less-than: -1 < 1
    applyStimulus(0, 1, 3'b000, 6'b0, 0, 0, 3'b010, 6'b101010, 32'hFFFF_FFFF, 1);
    waitGnt(who);
    checkOutput("slt_alu_sel", alu_sel, 4'b0011);
    #1 req1 = 0;
    waitDone(who);
    checkOutput("slt_result", result, 1);

    // AND through the function field, then an unknown op class
    applyStimulus(1, 0, 3'b010, 6'b100100, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000, 6'b0, 0, 0);
    waitGnt(who);
    #1 req0 = 0;
    waitDone(who);
    checkOutput("and_result", result, 32'h0000_00F0);
    applyStimulus(0, 1, 3'b000, 6'b0, 0, 0, 3'b011, 6'b100000, 1, 1);
    waitGnt(who);
    #1 req1 = 0;
    waitDone(who);
    checkOutput("badop_done_who", who, 1);
    checkOutput("badop_flag", illegal, 1);

    // Both requesters held from reset: alternating grants, three cycles apart
    applyStimulus(1, 1, 3'b000, 6'b0, 1, 1, 3'b001, 6'b0, 5, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      waitGnt(who);
      checkOutput("rr_order", who, k % 2);
      if (k > 0) checkOutput("rr_spacing", $time - t_prev, 30);
      t_prev = $time;
    end
    #1 req0 = 0; req1 = 0;
    waitDone(who);
    checkOutput("rr_last_result", result, 3);

    // Reset during EXEC drops the op
    applyStimulus(1, 0, 3'b000, 6'b0, 6, 6, 3'b000, 6'b0, 0, 0);
    waitGnt(who);
    #1 rst = 1'b1; req0 = 0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done0", done0, 0);
    checkOutput("abort_result", result, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1, 1, 3'b000, 6'b0, 2, 3, 3'b001, 6'b0, 9, 1);
    waitGnt(who);
    checkOutput("post_rst_who", who, 0);
    #1 req0 = 0; req1 = 0;
    waitDone(who);
    checkOutput("post_rst_result", result, 5);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before t=100000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
